hist_readout_seq: RTL and testbench

//  Sequences readout of the trigger-monitor histogram bank (8 histos x NBINS bins, 32b each).

---
 rtl/hist_readout_seq.sv | 181 ++++++++++++++++++
 tb/tb_hist_readout_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hist_readout_seq.sv
// hist_readout_seq: walks the histogram bank bin by bin. For each bin it snapshots
// all NHIST words and streams the bin index plus the words as bytes over a
// valid/ready link. It can optionally pulse the histogram clear when the walk ends.
// Every output is registered and is loaded from the next-state decode, so the
// outputs always agree with the FSM state register.
module hist_readout_seq #(
  parameter int NHIST      = 8,
  parameter int NBINS      = 16,
  parameter int SEL_LAT    = 3,
  parameter int CLR_CYCLES = 2
) (
  input  logic                  clk_adc,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_after,
  output logic [7:0]            histostosend,
  input  logic [32*NHIST-1:0]   histos_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  resethist,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = 4 * NHIST;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [7:0]     LAST_BIN  = 8'(NBINS - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [7:0]     SEL_LOAD  = 8'(SEL_LAT);
  localparam logic [7:0]     CLR_LOAD  = 8'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_LATCH     = 3'd2,
    S_SEND_IDX  = 3'd3,
    S_SEND_DATA = 3'd4,
    S_NEXT      = 3'd5,
    S_CLEAR     = 3'd6,
    S_FIN       = 3'd7
  } state_t;

  state_t               state, state_n;
  logic [7:0]           bin, bin_n;
  logic [7:0]           wait_cnt, wait_n;
  logic [BCW-1:0]       byte_cnt, byte_n;
  logic [32*NHIST-1:0]  snap, snap_n;
  logic                 clr_flag, clr_flag_n;
  logic [7:0]           sel_n;
  logic [7:0]           tx_data_n;
  logic                 tx_valid_n, resethist_n, busy_n, done_n;
  logic                 xfer;

  assign xfer = tx_valid & tx_ready;

  // Next-state, counter, snapshot and output decode for the readout sequence.
  always_comb begin
    state_n    = state;
    bin_n      = bin;
    wait_n     = wait_cnt;
    byte_n     = byte_cnt;
    snap_n     = snap;
    clr_flag_n = clr_flag;
    sel_n      = histostosend;
    case (state)
      S_IDLE: begin
        if (start) begin
          bin_n      = 8'd0;
          sel_n      = 8'd0;
          clr_flag_n = clear_after;
          wait_n     = SEL_LOAD;
          state_n    = S_SELECT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SELECT: begin
        // The registered histogram mux needs SEL_LAT cycles to follow the select change.
        if (wait_cnt == 8'd0) begin
          state_n = S_LATCH;
        end else begin
          wait_n = wait_cnt - 8'd1;
        end
      end
      S_LATCH: begin
        snap_n  = histos_in;
        state_n = S_SEND_IDX;
      end
      S_SEND_IDX: begin
        if (xfer) begin
          byte_n  = '0;
          state_n = S_SEND_DATA;
        end else begin
          state_n = S_SEND_IDX;
        end
      end
      S_SEND_DATA: begin
        // Shift the snapshot right so the next byte, LSB first and word 0 first, is always at [7:0].
        if (xfer) begin
          snap_n = snap >> 8;
          if (byte_cnt == LAST_BYTE) begin
            state_n = S_NEXT;
          end else begin
            byte_n = byte_cnt + BCW'(1);
          end
        end else begin
          state_n = S_SEND_DATA;
        end
      end
      S_NEXT: begin
        if (bin == LAST_BIN) begin
          wait_n  = CLR_LOAD;
          state_n = clr_flag ? S_CLEAR : S_FIN;
        end else begin
          bin_n   = bin + 8'd1;
          sel_n   = bin + 8'd1;
          wait_n  = SEL_LOAD;
          state_n = S_SELECT;
        end
      end
      S_CLEAR: begin
        if (wait_cnt == 8'd0) begin
          state_n = S_FIN;
        end else begin
          wait_n = wait_cnt - 8'd1;
        end
      end
      S_FIN: begin
        sel_n   = 8'd0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    tx_valid_n  = (state_n == S_SEND_IDX) || (state_n == S_SEND_DATA);
    resethist_n = (state_n == S_CLEAR);
    done_n      = (state_n == S_FIN);
    busy_n      = (state_n != S_IDLE);
    case (state_n)
      S_SEND_IDX:  tx_data_n = bin_n;
      S_SEND_DATA: tx_data_n = snap_n[7:0];
      default:     tx_data_n = 8'd0;
    endcase
  end

  // State, counters, snapshot and registered outputs; reset aborts any readout at once.
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state        <= S_IDLE;
      bin          <= 8'd0;
      wait_cnt     <= 8'd0;
      byte_cnt     <= '0;
      snap         <= '0;
      clr_flag     <= 1'b0;
      histostosend <= 8'd0;
      tx_data      <= 8'd0;
      tx_valid     <= 1'b0;
      resethist    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      bin          <= bin_n;
      wait_cnt     <= wait_n;
      byte_cnt     <= byte_n;
      snap         <= snap_n;
      clr_flag     <= clr_flag_n;
      histostosend <= sel_n;
      tx_data      <= tx_data_n;
      tx_valid     <= tx_valid_n;
      resethist    <= resethist_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

endmodule

// File: tb/tb_hist_readout_seq.sv
// tb_hist_readout_seq: scoreboard bench. The stimulus pushes the whole expected byte
// stream of every accepted readout into a queue. A negedge monitor pops and compares
// each byte, and it checks the handshake, the clear strobe and the done pulse.
module tb_hist_readout_seq;
  localparam int NHIST = 8, NBINS = 16, SEL_LAT = 3, CLR_CYCLES = 2;
  localparam int BYTES_PER_BIN = 1 + 4 * NHIST;
  localparam int READOUT_BYTES = NBINS * BYTES_PER_BIN;

  logic clk_adc = 1'b0;
  logic reset, start, clear_after, tx_ready;
  logic [7:0] histostosend, tx_data;
  logic [32*NHIST-1:0] histos_in;
  logic tx_valid, resethist, busy, done;

  always #5 clk_adc = ~clk_adc;

  hist_readout_seq #(.NHIST(NHIST), .NBINS(NBINS), .SEL_LAT(SEL_LAT), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk_adc(clk_adc), .reset(reset), .start(start), .clear_after(clear_after),
    .histostosend(histostosend), .histos_in(histos_in), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .resethist(resethist),
    .busy(busy), .done(done));

  int checks = 0, failures = 0;
  logic [7:0] sb[$];
  bit exp_clr[$];
  int ready_mode = 0;
  bit noise_en = 1'b0;
  int sent = 0, done_cnt = 0, rh_run = 0;
  int flush_req = 0, flush_seen = 0;
  logic [7:0] sel_dly[SEL_LAT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout/unexpected required=event at %0t", name, $time);
  endtask

  // Histogram word h for bin b, as the bank would present it.
  function automatic logic [31:0] hword(input int h, input int b);
    logic [31:0] hh;
    hh = 32'(h);
    return 32'h0101_0000 * hh + 32'(b);
  endfunction

  task automatic push_readout(input bit clr);
    logic [31:0] w;
    for (int b = 0; b < NBINS; b++) begin
      sb.push_back(8'(b));
      for (int h = 0; h < NHIST; h++) begin
        w = hword(h, b);
        for (int k = 0; k < 4; k++) sb.push_back(w[8*k +: 8]);
      end
    end
    exp_clr.push_back(clr);
  endtask

  // Environment: a SEL_LAT-deep registered histogram mux, optional noise while sending, and the ready pattern.
  initial begin
    int phase;
    phase = 0;
    for (int i = 0; i < SEL_LAT; i++) sel_dly[i] = 8'd0;
    histos_in = '0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk_adc);
      #1;
      for (int i = SEL_LAT - 1; i > 0; i--) sel_dly[i] = sel_dly[i-1];
      sel_dly[0] = histostosend;
      for (int h = 0; h < NHIST; h++)
        histos_in[32*h +: 32] = (noise_en && tx_valid) ? 32'($urandom) : hword(h, int'(sel_dly[SEL_LAT-1]));
      case (ready_mode)
        1: begin tx_ready = (phase == 0); phase = (phase + 1) % 3; end
        2: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: byte scoreboard, hold-while-stalled, back-to-back rate, clear length and done bookkeeping.
  initial begin
    bit prev_stall, prev_xfer, prev_done, prev_rh, c;
    logic [7:0] prev_data, e;
    prev_stall = 0; prev_xfer = 0; prev_done = 0; prev_rh = 0; prev_data = 8'd0;
    forever begin
      @(negedge clk_adc);
      if (flush_req != flush_seen) begin
        sb.delete(); exp_clr.delete();
        sent = 0; rh_run = 0;
        prev_stall = 0; prev_xfer = 0; prev_done = 0; prev_rh = 0;
        flush_seen = flush_req;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (ready_mode == 0 && prev_xfer && (sent % BYTES_PER_BIN) != 0)
        check("back_to_back", 32'(tx_valid), 32'd1);
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) fail_now("extra_byte");
        else begin
          e = sb.pop_front();
          check("byte", 32'(tx_data), 32'(e));
        end
        sent++;
      end
      if (resethist) rh_run++;
      if (done) begin
        done_cnt++;
        if (exp_clr.size() == 0) fail_now("extra_done");
        else begin
          c = exp_clr.pop_front();
          check("clear_len", 32'(rh_run), c ? 32'(CLR_CYCLES) : 32'd0);
          check("clear_then_done", 32'(prev_rh), 32'(c));
          check("bytes_left", 32'(sb.size()), 32'd0);
          check("readout_bytes", 32'(sent), 32'(READOUT_BYTES));
        end
        rh_run = 0;
        sent = 0;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_xfer  = tx_valid && tx_ready;
      prev_data  = tx_data;
      prev_done  = done;
      prev_rh    = resethist;
    end
  end

  task automatic do_start(input bit clr, input bit accepted);
    @(posedge clk_adc); #2;
    start = 1'b1;
    clear_after = clr;
    if (accepted) push_readout(clr);
    @(posedge clk_adc); #2;
    start = 1'b0;
    clear_after = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk_adc); #2;
      if (done_cnt > d0) got = 1;
    end
    if (!got) fail_now("done_timeout");
  endtask

  initial begin
    bit hit;
    reset = 1'b1; start = 1'b0; clear_after = 1'b0;
    repeat (3) @(posedge clk_adc);
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_resethist", 32'(resethist), 32'd0);
    check("rst_sel", 32'(histostosend), 32'd0);
    reset = 1'b0;

    // Full-rate readout without clear.
    ready_mode = 0;
    do_start(1'b0, 1'b1);
    wait_done(5000);

    // Ready accepts one cycle in three.
    ready_mode = 1;
    do_start(1'b0, 1'b1);
    wait_done(8000);

    // Histogram inputs churn while sending, with random ready.
    ready_mode = 2; noise_en = 1'b1;
    do_start(1'b0, 1'b1);
    wait_done(8000);
    noise_en = 1'b0;

    // Readout followed by a clear.
    ready_mode = 0;
    do_start(1'b1, 1'b1);
    wait_done(5000);

    // Reset lands with the 100th byte, then a fresh readout.
    do_start(1'b1, 1'b1);
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk_adc); #2;
      if (sent >= 99) hit = 1;
    end
    if (!hit) fail_now("byte99_timeout");
    reset = 1'b1;
    @(posedge clk_adc); #1;
    flush_req++;
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sel", 32'(histostosend), 32'd0);
    check("abort_resethist", 32'(resethist), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk_adc);
    #1;
    check("idle_after_abort", 32'(busy), 32'd0);
    do_start(1'b0, 1'b1);
    wait_done(5000);

    // A second start while busy must be ignored.
    do_start(1'b0, 1'b1);
    repeat (40) @(posedge clk_adc);
    do_start(1'b1, 1'b0);
    wait_done(5000);
    repeat (50) @(posedge clk_adc);
    #2;
    check("done_total", 32'(done_cnt), 32'd6);
    check("final_bytes_left", 32'(sb.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
